fifo_umbrales: RTL
==================

FIFO_UMBRALES -- requirements
Module: fifo_umbrales

Interface
REQ-001 Parameter DATA_W, default 6, SHALL set data word width.
REQ-002 Parameter DEPTH, default 8, SHALL set entry count; ADDR_W = log2(DEPTH) = 3.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 init  input  1  high: load umbral_alto/umbral_bajo into threshold registers.
REQ-006 umbral_alto  input  ADDR_W  almost-full threshold value.
REQ-007 umbral_bajo  input  ADDR_W  almost-empty threshold value.
REQ-008 FifoWrite  input  1  write request, data_in captured same edge.
REQ-009 data_in  input  DATA_W  write data.
REQ-010 FifoRead  input  1  read request.
REQ-011 data_out  output  DATA_W  read data, registered.
REQ-012 valid_out  output  1  data_out valid this cycle.
REQ-013 FifoFull  output  1  count == DEPTH.
REQ-014 FifoEmpty  output  1  count == 0.
REQ-015 almost_full  output  1  count >= threshold_alto.
REQ-016 almost_empty  output  1  count <= threshold_bajo.
REQ-017 error_out  output  1  sticky overflow/underflow flag.
REQ-018 count  output  ADDR_W+1  current occupancy, 0..DEPTH.

Function
REQ-019 Write SHALL be accepted when FifoWrite=1 and (FifoFull=0 or an accepted read occurs same cycle); data stored at wr_ptr, wr_ptr increments mod DEPTH.
REQ-020 Read SHALL be accepted when FifoRead=1 and FifoEmpty=0; entry at rd_ptr registered to data_out next edge, valid_out=1 for exactly that following cycle, rd_ptr increments mod DEPTH.
REQ-021 Read latency SHALL be 1 cycle; data_out holds last value when valid_out=0.
REQ-022 Accepted write and read same cycle SHALL leave count unchanged; when full both accepted; when empty only write accepted.
REQ-023 Write while full without accepted read SHALL be dropped, contents/pointers unchanged, error_out set.
REQ-024 Read while empty SHALL be ignored (valid_out=0 next cycle), error_out set, even if a write occurs same cycle.
REQ-025 error_out SHALL remain 1 until reset; no other input clears it.
REQ-026 Pointers SHALL wrap DEPTH-1 -> 0; count SHALL never exceed DEPTH or go below 0.
REQ-027 FifoFull, FifoEmpty, almost_full, almost_empty SHALL derive combinationally from registered count and threshold registers only.
REQ-028 init=1 SHALL load thresholds on the edge; new values affect flags from next cycle; FIFO data/pointers unaffected by init.
REQ-029 Data written then read SHALL emerge in write order (strict FIFO).

Reset
REQ-030 reset=1 at clock edge SHALL clear wr_ptr, rd_ptr, count, data_out, valid_out, error_out to 0.
REQ-031 reset SHALL set threshold_alto=6, threshold_bajo=1; reset dominates init, FifoWrite, FifoRead.
REQ-032 Reset mid-operation SHALL discard stored contents logically (FifoEmpty=1 next cycle); memory array itself need not be cleared.

Structure
REQ-033 DATA_W, DEPTH, ADDR_W and reset threshold constants SHALL reside in the shared project constants include used by maquina and probador.
REQ-034 Storage SHALL be a separate sub-module memoria_fifo (one write port, one registered read port); pointer/count/flag logic stays in fifo_umbrales.
REQ-035 Design SHALL be synthesizable to the project cmos cell library; behavioral and synthesized versions SHALL match cycle-for-cycle.

Verification
REQ-036 Reset, then 8 writes 0x01..0x08 -> FifoFull=1, count=8, almost_full=1 from 6th write; FifoEmpty=0.
REQ-037 Full, 8 reads -> data_out 0x01..0x08 each one cycle after request, valid_out=1 each, FifoEmpty=1 after last.
REQ-038 Count=8, FifoWrite+FifoRead same cycle with 0x2A -> count stays 8, 0x2A read out 8 reads later, error_out=0.
REQ-039 Full, write 0x3F alone -> dropped, error_out=1 stays 1; empty read after reset -> valid_out=0, error_out=1.
REQ-040 init=1 with umbral_alto=3, umbral_bajo=2 then 3 writes -> almost_full=1 at count=3, almost_empty=0 at count=3, =1 at count=2.
REQ-041 Reset asserted at count=5 -> next cycle count=0, FifoEmpty=1, thresholds 6/1, error_out=0; behavioral vs synthesized outputs compared every cycle.

Source files
------------

// File: rtl/fifo_umbrales_pkg.sv
// Shared constants for the threshold FIFO: word width, depth and reset-time thresholds.
package fifo_umbrales_pkg;
    localparam int FIFO_DATA_W   = 6;
    localparam int FIFO_DEPTH    = 8;
    localparam int FIFO_ADDR_W   = 3;
    localparam int THR_ALTO_RST  = 6;
    localparam int THR_BAJO_RST  = 1;
endpackage

// File: rtl/fifo_umbrales_memoria_fifo.sv
// Storage array for fifo_umbrales: one write port plus a registered read port.
// Read data appears one edge after i_re and holds otherwise; a same-address write returns the old word.
import fifo_umbrales_pkg::*;

module memoria_fifo #(
    parameter int DATA_W = FIFO_DATA_W,
    parameter int ADDR_W = FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    // The array is never cleared; only the output register is reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/fifo_umbrales.sv
// FIFO with programmable almost-full/almost-empty thresholds; 1-cycle read latency.
// No backpressure: writes when full (without a read) are dropped, reads when empty ignored, both set sticky error_out.
import fifo_umbrales_pkg::*;

module fifo_umbrales #(
    parameter int DATA_W = FIFO_DATA_W,
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic [ADDR_W-1:0] umbral_alto,
    input  logic [ADDR_W-1:0] umbral_bajo,
    input  logic              FifoWrite,
    input  logic [DATA_W-1:0] data_in,
    input  logic              FifoRead,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              FifoFull,
    output logic              FifoEmpty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              error_out,
    output logic [ADDR_W:0]   count
);
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W-1:0] r_thr_alto;
    logic [ADDR_W-1:0] r_thr_bajo;
    logic              r_valid;
    logic              r_error;
    logic              w_full;
    logic              w_empty;
    logic              w_rd_acc;
    logic              w_wr_acc;
    logic              w_err_evt;

    assign w_full    = (r_count == (ADDR_W+1)'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_rd_acc  = FifoRead && !w_empty;
    // A read in the same cycle frees the slot, so a full FIFO still accepts the write.
    assign w_wr_acc  = FifoWrite && (!w_full || w_rd_acc);
    assign w_err_evt = (FifoWrite && !w_wr_acc) || (FifoRead && w_empty);

    function automatic logic [ADDR_W-1:0] ptr_next(input logic [ADDR_W-1:0] p);
        return (p == ADDR_W'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_valid    <= 1'b0;
            r_error    <= 1'b0;
            r_thr_alto <= ADDR_W'(THR_ALTO_RST);
            r_thr_bajo <= ADDR_W'(THR_BAJO_RST);
        end else begin
            if (init) begin
                r_thr_alto <= umbral_alto;
                r_thr_bajo <= umbral_bajo;
            end
            if (w_wr_acc) r_wr_ptr <= ptr_next(r_wr_ptr);
            if (w_rd_acc) r_rd_ptr <= ptr_next(r_rd_ptr);
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_valid <= w_rd_acc;
            if (w_err_evt) r_error <= 1'b1;
        end
    end

    memoria_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr),
        .i_wdata (data_in),
        .i_re    (w_rd_acc),
        .i_raddr (r_rd_ptr),
        .o_rdata (data_out)
    );

    assign valid_out    = r_valid;
    assign error_out    = r_error;
    assign count        = r_count;
    assign FifoFull     = w_full;
    assign FifoEmpty    = w_empty;
    assign almost_full  = (r_count >= {1'b0, r_thr_alto});
    assign almost_empty = (r_count <= {1'b0, r_thr_bajo});
endmodule
